async_fifo: RTL and testbench
=============================

Name: async_fifo

Overview:
- Parameterised first-in/first-out data buffer between a producer and a consumer inside the digital system.
- Provides full/empty handshake flags and first-word-fall-through read data.
- This revision runs both ports from one clock domain, so no pointer synchronisers are needed.
- Port naming is kept compatible with the dual-clock FIFO family so it drops into existing sockets.

Parameters:
- Width_FIFO, 8: data word width in bits.
- Depth_FIFO, 8: number of storage entries; must be a power of 2 and at least 2. Pointer address width is A = log2(Depth_FIFO).

Ports:
- CLK  input  1  single clock for write and read sides; all state changes on rising edge.
- RST  input  1  reset, asynchronous and active-high: assertion immediately clears state, release is taken on CLK.
- W_INC  input  1  write request; data is accepted on a rising edge when W_INC=1 and FULL=0.
- WR_DATA  input  Width_FIFO  data written when the write is accepted.
- R_INC  input  1  read/pop request; the head entry is consumed on a rising edge when R_INC=1 and EMPTY=0.
- RD_DATA  output  Width_FIFO  current head entry (combinational from memory at the read pointer).
- FULL  output  1  high when Depth_FIFO entries are stored.
- EMPTY  output  1  high when no entries are stored.

Behaviour:
- Storage: Depth_FIFO x Width_FIFO register array.
- Pointers: write pointer and read pointer, each A+1 bits wide. The low A bits address memory; the MSB is a wrap bit.
- Pointers are kept in binary, with Gray-coded copies registered alongside them for the flag comparisons.
- Reset (RST=1, asynchronous): both pointers and Gray copies clear to 0 and all memory entries clear to 0. Outputs during reset: EMPTY=1, FULL=0, RD_DATA=0.
- Write: on a rising edge with W_INC=1 and FULL=0, mem[wptr[A-1:0]] <= WR_DATA and wptr increments by 1, wrapping modulo 2^(A+1).
- Write when FULL=1: ignored; memory and pointers are unchanged and no error is raised in the base build.
- Read: RD_DATA always equals mem[rptr[A-1:0]], i.e. first-word fall-through.
  - On a rising edge with R_INC=1 and EMPTY=0, rptr increments by 1.
  - RD_DATA shows the next entry after that edge.
- Read when EMPTY=1: ignored; rptr is unchanged and RD_DATA holds the stale memory value.
- EMPTY = (Gray wptr == Gray rptr). Flags are registered-pointer derived with zero extra latency: the flag updates in the same cycle the pointer updates.
- FULL = Gray wptr equals Gray rptr with the two MSBs inverted and the remaining bits equal. Equivalently: binary pointers differ only in the wrap bit.
- Write-to-read latency: a word written at edge N is visible on RD_DATA and clears EMPTY immediately after edge N.
- Simultaneous W_INC and R_INC in the same cycle:
  - Not full and not empty: both are accepted; occupancy is unchanged and the flags are unchanged.
  - When EMPTY: only the write is accepted.
  - When FULL: only the read is accepted; FULL deasserts after the edge.
- Wrap-around: pointers wrap seamlessly; ordering is preserved across any number of wraps.
- Level-held requests: W_INC or R_INC held high for multiple cycles performs one operation per edge until FULL or EMPTY blocks it.
- Reset mid-operation: all contents are discarded and the flags return immediately to the empty state.

Optional Feature:
- Macro: FIFO_STATUS_EN.
- Defined: adds three outputs.
  - COUNT: A+1 bits, equals wptr - rptr modulo 2^(A+1), ranging 0..Depth_FIFO.
  - OVERFLOW: 1 bit, sticky; set on any edge with W_INC=1 and FULL=1.
  - UNDERFLOW: 1 bit, sticky; set on any edge with R_INC=1 and EMPTY=1.
  - All three clear only on RST.
- Not defined: these ports and their logic are absent; the base behaviour is unchanged.

Test Plan:
- Reset: hold RST=1 with random inputs -> EMPTY=1, FULL=0, RD_DATA=0. After release with no requests, flags stay unchanged.
- Fill: write i*i for i=0..7 (W_INC pulsed every other cycle) -> EMPTY falls after the first write. FULL rises exactly after the 8th accepted write (value 49).
- Overflow: write 0xAA while FULL -> ignored. Subsequent 8 reads return 0,1,4,9,16,25,36,49 in order; EMPTY=1 after the last read; 0xAA is never seen.
- Partial drain and wrap: write 8, read 3 (expect 0,1,4), write 3 more (0x11,0x22,0x33) -> FULL=1. Draining returns 9,16,25,36,49,0x11,0x22,0x33.
- Simultaneous: with 4 stored, assert W_INC and R_INC for 10 cycles -> FULL and EMPTY stay 0 and data order is preserved. Repeat both requests while empty -> only the write lands (EMPTY=0, head = written value).
- Underflow and mid-op reset: R_INC held high while empty -> no pointer change. Asserting RST with 5 entries stored -> EMPTY=1 immediately, before the next edge. With FIFO_STATUS_EN: COUNT tracks occupancy; OVERFLOW and UNDERFLOW set in the overflow/underflow cases and clear on RST.

Source files
------------

// File: rtl/async_fifo.sv
// async_fifo: parameterised first-word-fall-through FIFO. Both ports run on
// one clock. Port names match the dual-clock FIFO family so this block fits
// the same sockets.
// Optional status outputs (COUNT, OVERFLOW, UNDERFLOW) are built only when the
// FIFO_STATUS_EN macro is defined.
//
// Handshake: the write side behaves as valid/ready, where W_INC is valid and
// ~FULL is ready. A word transfers on a rising edge only when both are high.
// The read side works the same way: R_INC is the pop request and ~EMPTY is
// valid. The head word is on RD_DATA whenever EMPTY is low, and it is consumed
// on a rising edge when R_INC is also high. Requests made while the FIFO is
// blocked are dropped. A blocked request does not stall the FIFO, and the
// requester does not need to hold it.
module async_fifo #(
  parameter int Width_FIFO = 8,
  parameter int Depth_FIFO = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [Width_FIFO-1:0] WR_DATA,
  input  logic                  R_INC,
  output logic [Width_FIFO-1:0] RD_DATA,
  output logic                  FULL,
  output logic                  EMPTY
`ifdef FIFO_STATUS_EN
  ,
  output logic [$clog2(Depth_FIFO):0] COUNT,
  output logic                        OVERFLOW,
  output logic                        UNDERFLOW
`endif
);

  localparam int A = $clog2(Depth_FIFO);
  localparam logic [A:0] PTR_ONE   = (A+1)'(1);
  // The Gray pointers differ in exactly their top two bits when the FIFO is full.
  localparam logic [A:0] FULL_MASK = (A+1)'(3 << (A-1));

  if (Depth_FIFO < 2 || (1 << A) != Depth_FIFO) begin : g_bad_depth
    $error("async_fifo: Depth_FIFO must be a power of 2 and at least 2");
  end

  logic [Width_FIFO-1:0] mem [Depth_FIFO];
  logic [A:0] wptr, rptr, wptr_next, rptr_next;
  logic [A:0] wgray, rgray;
  logic       wr_en, rd_en;

  function automatic logic [A:0] to_gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  assign wr_en     = W_INC & ~FULL;
  assign rd_en     = R_INC & ~EMPTY;
  assign wptr_next = wptr + PTR_ONE;
  assign rptr_next = rptr + PTR_ONE;

  // Write pointer and its registered Gray copy advance together on each accepted write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      wgray <= '0;
    end else if (wr_en) begin
      wptr  <= wptr_next;
      wgray <= to_gray(wptr_next);
    end
  end

  // Read pointer and its registered Gray copy advance together on each accepted pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rptr  <= '0;
      rgray <= '0;
    end else if (rd_en) begin
      rptr  <= rptr_next;
      rgray <= to_gray(rptr_next);
    end
  end

  // Storage array. It is cleared on reset so RD_DATA reads zero while empty after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < Depth_FIFO; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wptr[A-1:0]] <= WR_DATA;
    end
  end

  // First-word fall-through: the head entry is always presented on RD_DATA.
  assign RD_DATA = mem[rptr[A-1:0]];

  // Flags come from the registered Gray pointers, so they change in the same cycle as the pointers.
  assign EMPTY = (wgray == rgray);
  assign FULL  = ((wgray ^ rgray) == FULL_MASK);

`ifdef FIFO_STATUS_EN
  // Occupancy is taken directly from the binary pointers.
  assign COUNT = wptr - rptr;

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (W_INC && FULL)  OVERFLOW  <= 1'b1;
      if (R_INC && EMPTY) UNDERFLOW <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed self-checking bench for async_fifo. An expected-data
// queue serves as the reference model.
module tb_async_fifo;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         CLK = 1'b0;
  logic         RST;
  logic         W_INC;
  logic [W-1:0] WR_DATA;
  logic         R_INC;
  logic [W-1:0] RD_DATA;
  logic         FULL;
  logic         EMPTY;
`ifdef FIFO_STATUS_EN
  logic [A:0]   COUNT;
  logic         OVERFLOW;
  logic         UNDERFLOW;
`endif

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  async_fifo #(.Width_FIFO(W), .Depth_FIFO(D)) dut (
    .CLK(CLK),
    .RST(RST),
    .W_INC(W_INC),
    .WR_DATA(WR_DATA),
    .R_INC(R_INC),
    .RD_DATA(RD_DATA),
    .FULL(FULL),
    .EMPTY(EMPTY)
`ifdef FIFO_STATUS_EN
    ,
    .COUNT(COUNT),
    .OVERFLOW(OVERFLOW),
    .UNDERFLOW(UNDERFLOW)
`endif
  );

  // Clock and reset block
  always #5 CLK = ~CLK;

  // Checking task: every comparison goes through here
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".empty"}, 32'(EMPTY), 32'(exp_q.size() == 0));
    check({tag, ".full"},  32'(FULL),  32'(exp_q.size() == D));
`ifdef FIFO_STATUS_EN
    check({tag, ".count"}, 32'(COUNT), 32'(exp_q.size()));
`endif
  endtask

  task automatic check_head(input string tag);
    if (exp_q.size() > 0) check({tag, ".head"}, 32'(RD_DATA), 32'(exp_q[0]));
  endtask

  // Driver tasks
  task automatic push(input logic [W-1:0] d, input string tag);
    bit w_ok;
    w_ok    = (exp_q.size() < D);
    W_INC   = 1'b1;
    WR_DATA = d;
    step();
    W_INC   = 1'b0;
    if (w_ok) exp_q.push_back(d);
    check_flags(tag);
    check_head(tag);
  endtask

  task automatic pop(input string tag);
    bit r_ok;
    r_ok = (exp_q.size() > 0);
    check_head(tag);
    R_INC = 1'b1;
    step();
    R_INC = 1'b0;
    if (r_ok) void'(exp_q.pop_front());
    check_flags(tag);
  endtask

  task automatic both(input logic [W-1:0] d, input string tag);
    bit w_ok, r_ok;
    w_ok = (exp_q.size() < D);
    r_ok = (exp_q.size() > 0);
    check_head(tag);
    W_INC   = 1'b1;
    R_INC   = 1'b1;
    WR_DATA = d;
    step();
    W_INC = 1'b0;
    R_INC = 1'b0;
    if (r_ok) void'(exp_q.pop_front());
    if (w_ok) exp_q.push_back(d);
    check_flags(tag);
    check_head(tag);
  endtask

  task automatic idle(input string tag);
    step();
    check_flags(tag);
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) pop($sformatf("%s%0d", tag, i));
  endtask

  logic [W-1:0] sq [8] = '{8'd0, 8'd1, 8'd4, 8'd9, 8'd16, 8'd25, 8'd36, 8'd49};

  initial begin
    // Reset with random request activity
    RST     = 1'b1;
    W_INC   = 1'b0;
    R_INC   = 1'b0;
    WR_DATA = '0;
    for (int i = 0; i < 4; i++) begin
      W_INC   = 1'($urandom_range(0, 1));
      R_INC   = 1'($urandom_range(0, 1));
      WR_DATA = W'($urandom_range(0, 255));
      step();
    end
    check("rst.empty", 32'(EMPTY), 32'd1);
    check("rst.full",  32'(FULL),  32'd0);
    check("rst.rdata", 32'(RD_DATA), 32'd0);
`ifdef FIFO_STATUS_EN
    check("rst.ovf", 32'(OVERFLOW),  32'd0);
    check("rst.unf", 32'(UNDERFLOW), 32'd0);
`endif
    W_INC = 1'b0;
    R_INC = 1'b0;
    RST   = 1'b0;
    for (int i = 0; i < 3; i++) idle($sformatf("post_rst%0d", i));
    check("post_rst.rdata", 32'(RD_DATA), 32'd0);

    // Fill with i*i, with a write every other cycle
    for (int i = 0; i < 8; i++) begin
      push(sq[i], $sformatf("fill%0d", i));
      idle($sformatf("fill_gap%0d", i));
    end
`ifdef FIFO_STATUS_EN
    check("fill.ovf", 32'(OVERFLOW), 32'd0);
`endif

    // Overflow: 0xAA must be dropped
    push(8'hAA, "ovf_wr");
`ifdef FIFO_STATUS_EN
    check("ovf.sticky", 32'(OVERFLOW), 32'd1);
`endif
    drain("ovf_rd");
    check("ovf.rdata_stale", 32'(RD_DATA), 32'd0);

    // Partial drain, then wrap the pointers
    for (int i = 0; i < 8; i++) push(sq[i], $sformatf("wrap_fill%0d", i));
    for (int i = 0; i < 3; i++) pop($sformatf("wrap_pop%0d", i));
    push(8'h11, "wrap_w11");
    push(8'h22, "wrap_w22");
    push(8'h33, "wrap_w33");
    check("wrap.full", 32'(FULL), 32'd1);
    drain("wrap_drain");

    // Simultaneous read and write with 4 entries stored
    for (int i = 0; i < 4; i++) push(W'(8'h40 + i), $sformatf("sim_pre%0d", i));
    for (int i = 0; i < 10; i++) both(W'(8'h50 + i), $sformatf("sim%0d", i));
    drain("sim_drain");

    // Simultaneous requests while empty: only the write is accepted
    both(8'h77, "sim_empty");
    check("sim_empty.head", 32'(RD_DATA), 32'h77);
    pop("sim_empty_pop");

    // Simultaneous requests while full: only the read is accepted
    for (int i = 0; i < 8; i++) push(W'(8'h60 + i), $sformatf("simf_fill%0d", i));
    both(8'hEE, "sim_full");
    drain("simf_drain");

    // Underflow: a held read request while empty must not move the read pointer
    R_INC = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("unf%0d.empty", i), 32'(EMPTY), 32'd1);
    end
    R_INC = 1'b0;
`ifdef FIFO_STATUS_EN
    check("unf.sticky", 32'(UNDERFLOW), 32'd1);
`endif
    push(8'h5A, "unf_wr");
    pop("unf_rd");

    // Mid-operation reset: the flags must clear before the next edge
    for (int i = 0; i < 5; i++) push(W'(8'hC0 + i), $sformatf("mid%0d", i));
    RST = 1'b1;
    #1;
    check("mid_rst.empty", 32'(EMPTY),   32'd1);
    check("mid_rst.full",  32'(FULL),    32'd0);
    check("mid_rst.rdata", 32'(RD_DATA), 32'd0);
`ifdef FIFO_STATUS_EN
    check("mid_rst.ovf", 32'(OVERFLOW),  32'd0);
    check("mid_rst.unf", 32'(UNDERFLOW), 32'd0);
`endif
    exp_q.delete();
    step();
    RST = 1'b0;
    idle("after_mid_rst");
    push(8'h3C, "after_rst_wr");
    pop("after_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
